// File: rtl/gray2bin_arb_pkg.sv
// Shared types and helpers for the Gray-to-binary converter arbiter.
// Channel count and code width are fixed here so every file agrees on them.
package gray2bin_arb_pkg;

    localparam int MODULATION_ORDER = 16;
    localparam int NUM_CH           = 4;
    localparam int BW               = $clog2(MODULATION_ORDER);
    localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef logic [CH_W-1:0] ch_t;

    typedef struct packed {
        logic vld;
        ch_t  ch;
    } tag_t;

    // First set bit of valid_vec scanning upward from ptr, wrapping.
    function automatic logic [NUM_CH-1:0] rr_pick(
        input logic [NUM_CH-1:0] valid_vec,
        input ch_t               ptr
    );
        logic [NUM_CH-1:0] grant;
        ch_t               idx;
        grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ch_t'((int'(ptr) + k) % NUM_CH);
            if (valid_vec[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/gray2bin_arb_rsp_fifo.sv
// Per-channel response FIFO; head word is shown directly, zero when empty.
// A write is accepted while full if a pop happens in the same cycle.
module gray2bin_arb_rsp_fifo
    import gray2bin_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [BW-1:0] i_data,
    input  logic          i_rd,
    output logic          o_valid,
    output logic [BW-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop   = i_rd & (r_count != '0);
    assign w_push  = i_wr & ((r_count != CNT_FULL) | w_pop);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gray2bin_arbiter.sv
// Round-robin sharing of one pipelined gray2bin converter among NUM_CH channels,
// with a tag pipe steering results into credit-protected response FIFOs.
module gray2bin_arbiter
    import gray2bin_arb_pkg::*;
#(
    parameter int CONV_LATENCY = 5,
    parameter int RSP_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*BW-1:0] req_gray,
    output logic [NUM_CH-1:0]    req_ready,
    output logic                 conv_i_dv,
    output logic [BW-1:0]        conv_gray,
    input  logic                 conv_o_dv,
    input  logic [BW-1:0]        conv_binary,
    output logic [NUM_CH-1:0]    rsp_valid,
    output logic [NUM_CH*BW-1:0] rsp_binary,
    input  logic [NUM_CH-1:0]    rsp_ready,
    output logic                 err_tag
);

    localparam int CR_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CR_W-1:0] CR_FULL = CR_W'(RSP_DEPTH);

    logic [CR_W-1:0]   r_credit [NUM_CH];
    ch_t               r_rr_ptr;
    logic              r_conv_dv;
    logic [BW-1:0]     r_conv_gray;
    logic              r_err;
    // Stage 0 runs alongside the issue register, so the last stage meets conv_o_dv.
    tag_t              r_tag [CONV_LATENCY+1];

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_fifo_wr;
    logic              w_xfer;
    ch_t               w_gnt_ch;
    logic [BW-1:0]     w_gnt_gray;
    tag_t              w_tag_out;
    logic              w_ret_ok;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_elig[i] = req_valid[i] & (r_credit[i] != '0);
        end
    end

    assign w_grant   = rr_pick(w_elig, r_rr_ptr);
    assign w_xfer    = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_gnt_ch   = '0;
        w_gnt_gray = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_gnt_ch   = ch_t'(i);
                w_gnt_gray = req_gray[i*BW +: BW];
            end
        end
    end

    assign w_tag_out = r_tag[CONV_LATENCY];
    assign w_ret_ok  = conv_o_dv & w_tag_out.vld;
    assign w_pop     = rsp_valid & rsp_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_fifo_wr[i] = w_ret_ok & (w_tag_out.ch == ch_t'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_conv_dv   <= 1'b0;
            r_conv_gray <= '0;
            r_err       <= 1'b0;
            for (int k = 0; k <= CONV_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_credit[i] <= CR_FULL;
            end
        end else begin
            r_conv_dv <= w_xfer;
            if (w_xfer) begin
                r_conv_gray <= w_gnt_gray;
                r_rr_ptr    <= (w_gnt_ch == ch_t'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
            end
            r_tag[0] <= '{vld: w_xfer, ch: w_gnt_ch};
            for (int k = 1; k <= CONV_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            if (conv_o_dv != w_tag_out.vld) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - 1'b1;
                    2'b01:   r_credit[i] <= r_credit[i] + 1'b1;
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

    assign conv_i_dv = r_conv_dv;
    assign conv_gray = r_conv_gray;
    assign err_tag   = r_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rsp
        gray2bin_arb_rsp_fifo #(
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_wr    (w_fifo_wr[gi]),
            .i_data  (conv_binary),
            .i_rd    (rsp_ready[gi]),
            .o_valid (rsp_valid[gi]),
            .o_data  (rsp_binary[gi*BW +: BW])
        );
    end

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Bench for gray2bin_arbiter: converter model, round-robin/credit reference model,
// and a per-channel scoreboard checked by a monitor on the falling edge.
module tb_gray2bin_arbiter;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int L   = 5;
    localparam int DEP = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   req_valid = '0;
    logic [NCH*W-1:0] req_gray = '0;
    logic [NCH-1:0]   req_ready;
    logic             conv_i_dv;
    logic [W-1:0]     conv_gray;
    logic             conv_o_dv;
    logic [W-1:0]     conv_binary;
    logic [NCH-1:0]   rsp_valid;
    logic [NCH*W-1:0] rsp_binary;
    logic [NCH-1:0]   rsp_ready = '0;
    logic             err_tag;
    logic             inj = 1'b0;

    gray2bin_arbiter #(
        .CONV_LATENCY (L),
        .RSP_DEPTH    (DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_gray    (req_gray),
        .req_ready   (req_ready),
        .conv_i_dv   (conv_i_dv),
        .conv_gray   (conv_gray),
        .conv_o_dv   (conv_o_dv),
        .conv_binary (conv_binary),
        .rsp_valid   (rsp_valid),
        .rsp_binary  (rsp_binary),
        .rsp_ready   (rsp_ready),
        .err_tag     (err_tag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int gcnt [NCH];

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Shared converter model: fixed L-cycle pipeline, cleared with the system reset.
    logic [L-1:0] cv_dv;
    logic [W-1:0] cv_bin [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_dv <= '0;
            for (int k = 0; k < L; k++) cv_bin[k] <= '0;
        end else begin
            cv_dv[0]  <= conv_i_dv;
            cv_bin[0] <= g2b(conv_gray);
            for (int k = 1; k < L; k++) begin
                cv_dv[k]  <= cv_dv[k-1];
                cv_bin[k] <= cv_bin[k-1];
            end
        end
    end
    assign conv_o_dv   = cv_dv[L-1] | inj;
    assign conv_binary = cv_bin[L-1];

    // Reference model state and scoreboard.
    int           m_ptr;
    int           m_cred [NCH];
    logic         exp_err;
    logic [W-1:0] q [NCH][$];

    initial begin
        for (int c = 0; c < NCH; c++) gcnt[c] = 0;
    end

    always @(negedge clk) begin
        logic [NCH-1:0] eg;
        logic [W-1:0]   ev;
        int             c;
        if (rst) begin
            chk("reset_outputs",
                {req_ready, conv_i_dv, conv_gray, rsp_valid, rsp_binary, err_tag}, 0);
            m_ptr   = 0;
            exp_err = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_cred[i] = DEP;
                q[i].delete();
            end
        end else begin
            eg = '0;
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (eg == '0 && req_valid[c] && m_cred[c] > 0) eg[c] = 1'b1;
            end
            chk("grant", req_ready, eg);
            for (int i = 0; i < NCH; i++) begin
                if (eg[i]) begin
                    m_cred[i] = m_cred[i] - 1;
                    m_ptr     = (i + 1) % NCH;
                end
                if (req_valid[i] && req_ready[i]) begin
                    gcnt[i]++;
                    q[i].push_back(g2b(req_gray[i*W +: W]));
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (rsp_valid[i]) begin
                    if (q[i].size() == 0) begin
                        chk("stale_rsp", {28'd0, rsp_binary[i*W +: W]}, 32'hDEAD);
                    end else if (rsp_ready[i]) begin
                        ev = q[i].pop_front();
                        chk("rsp_data", rsp_binary[i*W +: W], ev);
                        m_cred[i] = m_cred[i] + 1;
                    end
                end
            end
            chk("err_tag", err_tag, exp_err);
            if (inj) exp_err = 1'b1;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        step(20);
        rsp_ready = '0;
    endtask

    int base;
    int t0;
    int lat;
    logic seen;

    initial begin
        // Reset, then all four requesting: 0,1,2,3,0.
        step(3);
        rst = 1'b0;
        step(1);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_sequence", req_ready, 32'(1 << (k % NCH)));
            step(1);
        end
        drain();

        // Latency and conversion of 4'b1100 on channel 2.
        req_valid = 4'b0100;
        req_gray  = 16'h0C00;
        t0 = cyc;
        #1;
        chk("ch2_grant", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid[2]) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        chk("latency", lat, 7);
        chk("ch2_binary", rsp_binary[2*W +: W], 4'b1000);
        step(1);
        drain();

        // Credits: four transfers without pops, one pop buys exactly one more.
        req_valid = 4'b0010;
        base = gcnt[1];
        step(15);
        chk("credit_limit", gcnt[1] - base, 4);
        #1;
        chk("ch1_blocked", req_ready[1], 1'b0);
        rsp_ready = 4'b0010;
        step(1);
        rsp_ready = '0;
        base = gcnt[1];
        step(15);
        chk("one_pop_one_grant", gcnt[1] - base, 1);
        drain();

        // Fairness: ch0 out of credit is skipped; pointer wraps to 0.
        req_valid = 4'b0001;
        base = gcnt[0];
        step(10);
        chk("ch0_credit_use", gcnt[0] - base, 4);
        req_valid = 4'b1000;
        #1;
        chk("ch3_alone", req_ready, 4'b1000);
        step(1);
        req_valid = 4'b1001;
        #1;
        chk("skip_ch0", req_ready, 4'b1000);
        step(1);
        req_valid = 4'b1100;
        #1;
        chk("ptr_wrapped", req_ready, 4'b0100);
        step(1);
        drain();

        // Tag error: stray converter strobe with nothing in flight.
        step(10);
        inj = 1'b1;
        step(1);
        inj = 1'b0;
        step(3);
        chk("err_sticky", err_tag, 1'b1);
        chk("err_no_write", rsp_valid, 4'b0000);

        // Mid-operation reset with conversions in flight.
        req_valid = 4'b0111;
        req_gray  = 16'h0ABC;
        step(3);
        req_valid = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        rsp_ready = '1;
        step(20);
        chk("no_stale_after_rst", rsp_valid, 4'b0000);
        rsp_ready = '0;
        req_valid = 4'b0001;
        base = gcnt[0];
        step(10);
        chk("credits_restored", gcnt[0] - base, 4);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            req_valid = NCH'($urandom);
            req_gray  = (NCH*W)'($urandom);
            rsp_ready = NCH'($urandom);
            step(1);
        end
        req_valid = '0;
        rsp_ready = '1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step(1);
            seen = (q[0].size() + q[1].size() + q[2].size() + q[3].size()) == 0;
        end
        chk("drain_empty", seen, 1'b1);
        step(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
